present_encryptor_ctrl: RTL and testbench
=========================================

# present_encryptor_ctrl

Sequencing controller for the PRESENT-80 encryption core. It stores the 80-bit key, accepts plaintext blocks over a valid/ready interface, and drives the core's shared 80-bit load bus, key-load and data-load strobes. It times the 31 rounds and captures the ciphertext before the free-running core corrupts it, then presents it on a valid/ready output. The core updates its key register during every block, so the controller reloads the key before each block.

## Interface
- No parameters. Round count is fixed at 31 for PRESENT-80.
- clk_i  in  1  clock; all logic on the rising edge
- rst_i  in  1  reset, synchronous, active-high
- key_i  in  80  cipher key
- key_valid_i  in  1  key offered
- key_ready_o  out  1  key can be accepted
- pt_i  in  64  plaintext block
- pt_valid_i  in  1  plaintext offered
- pt_ready_o  out  1  plaintext can be accepted
- ct_o  out  64  ciphertext, registered
- ct_valid_o  out  1  ciphertext valid
- ct_ready_i  in  1  ciphertext consumed
- busy_o  out  1  high when the FSM is not in IDLE
- core_data_o  out  80  drives the core's data_i bus
- core_key_load_o  out  1  drives the core's key_load
- core_data_load_o  out  1  drives the core's data_load
- core_data_i  in  64  the core's data_o output

## Operation
- FSM states and behaviour:
  - **IDLE**
    - key_ready_o=1.
    - pt_ready_o=key_ok.
  - **LOAD_KEY**: 1 cycle.
  - **LOAD_DATA**: 1 cycle; round_cnt<=1.
  - **RUN**: 30 cycles.
  - **CAPTURE**: 1 cycle.
  - **OUT**: ct_valid_o=1.
- Internal registers:
  - key_reg (80 bits)
  - pt_reg (64 bits)
  - key_ok (1 bit)
  - round_cnt (5 bits)
  - ct_reg (64 bits), drives ct_o
- Key handshake:
  - Fires when key_valid_i && key_ready_o.
  - Effect: key_reg<=key_i, key_ok<=1.
  - A key is retained across blocks until it is replaced or reset.
- Plaintext handshake:
  - Fires when pt_valid_i && pt_ready_o.
  - Effect: pt_reg<=pt_i, IDLE->LOAD_KEY.
  - Plaintext offered before any key has been loaded is stalled (pt_ready_o=0).
- Key and plaintext in the same IDLE cycle: both are accepted when key_ok=1, and the block is encrypted with the new key.
- Core drive, decoded from FSM state:
  - core_key_load_o=1 in IDLE, LOAD_KEY, CAPTURE and OUT. This holds the core's state quiescent and keeps its key register equal to key_reg.
  - core_key_load_o=0 in LOAD_DATA and RUN.
  - core_data_load_o=1 only in LOAD_DATA.
  - core_data_o={16'h0000, pt_reg} in LOAD_DATA; key_reg in every other state.
- RUN:
  - round_cnt increments every cycle, mirroring the core's counter.
  - When round_cnt==30, go to CAPTURE; the core reaches round 31 on that same edge.
- CAPTURE: ct_reg<=core_data_i, then go to OUT.
- OUT:
  - Holds ct_valid_o=1 with ct_o stable until ct_ready_i=1.
  - Then goes to IDLE with ct_valid_o=0 on the next cycle.
  - Backpressure of any length is allowed.
- key_ready_o and pt_ready_o are 0 in every non-IDLE state, so the key cannot change mid-block.
- round_cnt never wraps; its maximum is 30 in RUN.

## Timing
- Counting the acceptance cycle (pt handshake in IDLE) as cycle 0:
  - cycle 1: LOAD_KEY
  - cycle 2: LOAD_DATA
  - cycles 3–32: RUN
  - cycle 33: CAPTURE
  - cycle 34: first cycle with ct_valid_o=1
- Latency is 34 cycles from plaintext acceptance to ciphertext valid.
- Minimum back-to-back period is 35 cycles. With ct_ready_i held at 1, OUT lasts 1 cycle, IDLE lasts 1 cycle, and the next pt can be accepted in that IDLE cycle.
- Reset values (after the rst_i edge):
  - state=IDLE
  - key_reg=0, pt_reg=0, ct_reg=0, round_cnt=0
  - key_ok=0
  - outputs: ct_valid_o=0, busy_o=0, key_ready_o=1, pt_ready_o=0, core_key_load_o=1, core_data_load_o=0, core_data_o=0
- Reset mid-operation in any state:
  - Aborts the block; the ciphertext is discarded and not presented.
  - key_ok is cleared, so a new key is required.
  - The core has no reset and is re-initialised by the controller's loads.
- ct_o changes only in CAPTURE, and never while ct_valid_o=1.

## Test plan
- **Zero vector:** key 0, pt 64'h0 → ct_o=64'h5579C1387B228445, with ct_valid_o rising exactly 34 cycles after pt acceptance.
- **Key held across blocks:** key 80'hFFFFFFFFFFFFFFFFFFFF, then pt 64'h0 followed by pt 64'hFFFFFFFFFFFFFFFF, both with the same key → E72C46C0F5945049, then 3333DCD3213210D2. This proves the key is reloaded before each block.
- **Backpressure:** key 0, pt all-F, ct_ready_i low for 20 cycles → ct_o=A112FFC72F68417B held stable throughout. pt_ready_o=0 and key_ready_o=0 until the OUT->IDLE transition.
- **Gating and collisions:**
  - pt_valid_i before any key → no acceptance and busy_o=0.
  - Then key and pt offered in the same cycle → the key is accepted and pt is stalled (key_ok was 0); pt is accepted next cycle.
  - Then, with key_ok=1, key 0 and pt 0 offered in the same IDLE cycle → both are accepted and the ciphertext is 5579C1387B228445.
- **Mid-operation reset:** assert rst_i in RUN at round_cnt=15 → IDLE and ct_valid_o=0 next cycle, with no ciphertext output. After reloading key 0 and pt 0, the result is 5579C1387B228445.

Source files
------------

// File: rtl/present_encryptor_ctrl.sv
// Sequencing controller for a free-running PRESENT-80 core: holds the key, feeds
// plaintext over the shared load bus, times 31 rounds and captures the ciphertext.
module present_encryptor_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [79:0] key_i,
    input  logic        key_valid_i,
    output logic        key_ready_o,
    input  logic [63:0] pt_i,
    input  logic        pt_valid_i,
    output logic        pt_ready_o,
    output logic [63:0] ct_o,
    output logic        ct_valid_o,
    input  logic        ct_ready_i,
    output logic        busy_o,
    output logic [79:0] core_data_o,
    output logic        core_key_load_o,
    output logic        core_data_load_o,
    input  logic [63:0] core_data_i
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        LOAD_DATA,
        RUN,
        CAPTURE,
        OUT
    } state_t;

    // Last RUN value of round_cnt; the core completes its final round on that edge.
    localparam logic [4:0] LAST_RUN_CNT = 5'd30;

    state_t      state;
    logic [79:0] key_reg;
    logic [63:0] pt_reg;
    logic [63:0] ct_reg;
    logic        key_ok;
    logic [4:0]  round_cnt;

    logic key_fire;
    logic pt_fire;

    assign key_fire = key_valid_i && key_ready_o;
    assign pt_fire  = pt_valid_i && pt_ready_o;
    assign ct_o     = ct_reg;

    // Outputs are registered alongside the state, so each transition also sets
    // the values the next state must present.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= IDLE;
            key_reg          <= '0;
            pt_reg           <= '0;
            ct_reg           <= '0;
            key_ok           <= 1'b0;
            round_cnt        <= '0;
            key_ready_o      <= 1'b1;
            pt_ready_o       <= 1'b0;
            ct_valid_o       <= 1'b0;
            busy_o           <= 1'b0;
            core_key_load_o  <= 1'b1;
            core_data_load_o <= 1'b0;
            core_data_o      <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads the
            // pre-edge values and the order of statements inside the case is irrelevant.
            case (state)
                IDLE: begin
                    if (key_fire) begin
                        key_reg     <= key_i;
                        key_ok      <= 1'b1;
                        core_data_o <= key_i;
                    end
                    if (pt_fire) begin
                        pt_reg      <= pt_i;
                        state       <= LOAD_KEY;
                        key_ready_o <= 1'b0;
                        pt_ready_o  <= 1'b0;
                        busy_o      <= 1'b1;
                    end else begin
                        pt_ready_o  <= key_ok || key_fire;
                    end
                end
                LOAD_KEY: begin
                    state            <= LOAD_DATA;
                    core_key_load_o  <= 1'b0;
                    core_data_load_o <= 1'b1;
                    core_data_o      <= {16'h0000, pt_reg};
                end
                LOAD_DATA: begin
                    state            <= RUN;
                    round_cnt        <= 5'd1;
                    core_data_load_o <= 1'b0;
                    core_data_o      <= key_reg;
                end
                RUN: begin
                    if (round_cnt == LAST_RUN_CNT) begin
                        state           <= CAPTURE;
                        core_key_load_o <= 1'b1;
                    end else begin
                        round_cnt       <= round_cnt + 5'd1;
                    end
                end
                CAPTURE: begin
                    ct_reg     <= core_data_i;
                    ct_valid_o <= 1'b1;
                    state      <= OUT;
                end
                OUT: begin
                    if (ct_ready_i) begin
                        state       <= IDLE;
                        ct_valid_o  <= 1'b0;
                        busy_o      <= 1'b0;
                        key_ready_o <= 1'b1;
                        pt_ready_o  <= key_ok;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_present_encryptor_ctrl.sv
// Bench for present_encryptor_ctrl: a behavioural free-running PRESENT-80 core
// hangs off the load bus, and results are checked against a whole-cipher model.
module tb_present_encryptor_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [79:0] key_i;
    logic        key_valid_i;
    logic        key_ready_o;
    logic [63:0] pt_i;
    logic        pt_valid_i;
    logic        pt_ready_o;
    logic [63:0] ct_o;
    logic        ct_valid_o;
    logic        ct_ready_i;
    logic        busy_o;
    logic [79:0] core_data_o;
    logic        core_key_load_o;
    logic        core_data_load_o;
    logic [63:0] core_data_i;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_acc = 0;
    int prev_acc = 0;
    logic [79:0] cur_key = '0;

    present_encryptor_ctrl dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .key_i           (key_i),
        .key_valid_i     (key_valid_i),
        .key_ready_o     (key_ready_o),
        .pt_i            (pt_i),
        .pt_valid_i      (pt_valid_i),
        .pt_ready_o      (pt_ready_o),
        .ct_o            (ct_o),
        .ct_valid_o      (ct_valid_o),
        .ct_ready_i      (ct_ready_i),
        .busy_o          (busy_o),
        .core_data_o     (core_data_o),
        .core_key_load_o (core_key_load_o),
        .core_data_load_o(core_data_load_o),
        .core_data_i     (core_data_i)
    );

    initial forever #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // ---------------- PRESENT-80 primitives ----------------
    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
            4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
            4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
            4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;
            default: return 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] sub64(input logic [63:0] s);
        logic [63:0] o;
        for (int i = 0; i < 16; i++) o[4*i +: 4] = sbox(s[4*i +: 4]);
        return o;
    endfunction

    function automatic logic [63:0] perm(input logic [63:0] s);
        logic [63:0] o;
        for (int i = 0; i < 63; i++) o[(i * 16) % 63] = s[i];
        o[63] = s[63];
        return o;
    endfunction

    function automatic logic [79:0] ks(input logic [79:0] k, input int r);
        logic [79:0] nk;
        nk = {k[18:0], k[79:19]};
        nk[79:76] = sbox(nk[79:76]);
        nk[19:15] = nk[19:15] ^ 5'(r);
        return nk;
    endfunction

    function automatic logic [63:0] present80(input logic [79:0] key, input logic [63:0] pt);
        logic [63:0] s;
        logic [79:0] k;
        s = pt;
        k = key;
        for (int r = 1; r <= 31; r++) begin
            s = perm(sub64(s ^ k[79:16]));
            k = ks(k, r);
        end
        return s ^ k[79:16];
    endfunction

    // ---------------- behavioural core ----------------
    // key_load holds the state and reloads the key; otherwise one round per edge,
    // with data_load substituting the bus value for the state as round input.
    logic [63:0] cm_state = '0;
    logic [79:0] cm_key   = '0;
    int          cm_ctr   = 1;

    always @(posedge clk_i) begin
        if (core_key_load_o) begin
            cm_key <= core_data_o;
            cm_ctr <= 1;
        end else begin
            cm_state <= perm(sub64((core_data_load_o ? core_data_o[63:0] : cm_state) ^ cm_key[79:16]));
            cm_key   <= ks(cm_key, cm_ctr);
            cm_ctr   <= cm_ctr + 1;
        end
    end
    assign core_data_i = cm_state ^ cm_key[79:16];

    // ---------------- helpers ----------------
    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset;
        rst_i = 1'b1;
        tick;
        tick;
        rst_i = 1'b0;
        cur_key = '0;
    endtask

    task automatic load_key(input logic [79:0] k);
        int n;
        key_i = k;
        key_valid_i = 1'b1;
        n = 0;
        while (key_ready_o !== 1'b1 && n < 100) begin
            tick;
            n++;
        end
        total++;
        if (key_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL load_key ready timeout got=%b exp=1", key_ready_o);
        end
        tick;
        key_valid_i = 1'b0;
        cur_key = k;
        total++;
        if (pt_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL load_key pt_ready after key got=%b exp=1", pt_ready_o);
        end
    endtask

    // Called at cycle 1 of a block (the cycle after plaintext acceptance).
    task automatic wait_ct(input logic [63:0] pt, input logic [63:0] exp, input int bp, input string name);
        int n;
        bit ok;
        total++;
        if (core_key_load_o !== 1'b1 || core_data_load_o !== 1'b0 || core_data_o !== cur_key) begin
            bad++;
            $display("FAIL %s key_drive got kl=%b dl=%b bus=%h exp kl=1 dl=0 bus=%h",
                     name, core_key_load_o, core_data_load_o, core_data_o, cur_key);
        end
        tick;
        n = 2;
        total++;
        if (core_key_load_o !== 1'b0 || core_data_load_o !== 1'b1 || core_data_o !== {16'h0000, pt}) begin
            bad++;
            $display("FAIL %s data_drive got kl=%b dl=%b bus=%h exp kl=0 dl=1 bus=%h",
                     name, core_key_load_o, core_data_load_o, core_data_o, {16'h0000, pt});
        end
        ok = 1'b1;
        while (ct_valid_o !== 1'b1 && n < 100) begin
            if (busy_o !== 1'b1 || key_ready_o !== 1'b0 || pt_ready_o !== 1'b0) ok = 1'b0;
            tick;
            n++;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s busy_gating got a non-idle cycle with ready high or busy low, exp busy=1 ready=0", name);
        end
        total++;
        if (n !== 34) begin
            bad++;
            $display("FAIL %s latency got=%0d exp=34", name, n);
        end
        total++;
        if (ct_o !== exp) begin
            bad++;
            $display("FAIL %s ciphertext got=%h exp=%h", name, ct_o, exp);
        end
        if (bp > 0) begin
            ct_ready_i = 1'b0;
            ok = 1'b1;
            for (int i = 0; i < bp; i++) begin
                tick;
                if (ct_valid_o !== 1'b1 || ct_o !== exp || key_ready_o !== 1'b0 || pt_ready_o !== 1'b0) ok = 1'b0;
            end
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL %s backpressure_hold got valid=%b ct=%h exp valid=1 ct=%h", name, ct_valid_o, ct_o, exp);
            end
            ct_ready_i = 1'b1;
        end
        tick;
        total++;
        if (ct_valid_o !== 1'b0 || busy_o !== 1'b0 || key_ready_o !== 1'b1 || pt_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL %s release got valid=%b busy=%b kr=%b pr=%b exp 0 0 1 1",
                     name, ct_valid_o, busy_o, key_ready_o, pt_ready_o);
        end
    endtask

    task automatic encrypt(input bit with_key, input logic [79:0] k, input logic [63:0] pt,
                           input logic [63:0] exp, input int bp, input string name);
        int n;
        pt_i = pt;
        pt_valid_i = 1'b1;
        if (with_key) begin
            key_i = k;
            key_valid_i = 1'b1;
        end
        n = 0;
        while (pt_ready_o !== 1'b1 && n < 100) begin
            tick;
            n++;
        end
        total++;
        if (pt_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL %s pt_accept timeout got=%b exp=1", name, pt_ready_o);
            pt_valid_i = 1'b0;
            key_valid_i = 1'b0;
            return;
        end
        tick;
        pt_valid_i = 1'b0;
        key_valid_i = 1'b0;
        if (with_key) cur_key = k;
        prev_acc = last_acc;
        last_acc = cyc;
        wait_ct(pt, exp, bp, name);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        do_reset;
        total++;
        if (ct_valid_o !== 1'b0 || busy_o !== 1'b0 || key_ready_o !== 1'b1 || pt_ready_o !== 1'b0 ||
            core_key_load_o !== 1'b1 || core_data_load_o !== 1'b0 || core_data_o !== 80'h0 || ct_o !== 64'h0) begin
            bad++;
            $display("FAIL reset_state got v=%b b=%b kr=%b pr=%b kl=%b dl=%b bus=%h ct=%h exp 0 0 1 0 1 0 0 0",
                     ct_valid_o, busy_o, key_ready_o, pt_ready_o, core_key_load_o, core_data_load_o, core_data_o, ct_o);
        end
    endtask

    task automatic test_zero_vector;
        load_key(80'h0);
        encrypt(1'b0, '0, 64'h0, 64'h5579C1387B228445, 0, "zero_vector");
    endtask

    task automatic test_key_held;
        load_key({80{1'b1}});
        encrypt(1'b0, '0, 64'h0, 64'hE72C46C0F5945049, 0, "held_a");
        encrypt(1'b0, '0, {64{1'b1}}, 64'h3333DCD3213210D2, 0, "held_b");
        total++;
        if (last_acc - prev_acc !== 35) begin
            bad++;
            $display("FAIL held_period got=%0d exp=35", last_acc - prev_acc);
        end
    endtask

    task automatic test_backpressure;
        load_key(80'h0);
        encrypt(1'b0, '0, {64{1'b1}}, 64'hA112FFC72F68417B, 20, "backpressure");
    endtask

    task automatic test_gating;
        logic [79:0] kg;
        logic [63:0] pg;
        bit ok;
        kg = {16'($urandom), $urandom, $urandom};
        pg = {$urandom, $urandom};
        do_reset;
        pt_i = pg;
        pt_valid_i = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (pt_ready_o !== 1'b0 || busy_o !== 1'b0) ok = 1'b0;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL gate_no_key got pr=%b busy=%b exp 0 0", pt_ready_o, busy_o);
        end
        key_i = kg;
        key_valid_i = 1'b1;
        total++;
        if (key_ready_o !== 1'b1 || pt_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL gate_first_key got kr=%b pr=%b exp 1 0", key_ready_o, pt_ready_o);
        end
        tick;
        key_valid_i = 1'b0;
        total++;
        if (busy_o !== 1'b0 || pt_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL gate_pt_stalled got busy=%b pr=%b exp 0 1", busy_o, pt_ready_o);
        end
        tick;
        pt_valid_i = 1'b0;
        cur_key = kg;
        total++;
        if (busy_o !== 1'b1) begin
            bad++;
            $display("FAIL gate_pt_accept got busy=%b exp 1", busy_o);
        end
        wait_ct(pg, present80(kg, pg), 0, "gate_block");
        total++;
        if (key_ready_o !== 1'b1 || pt_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL collide_ready got kr=%b pr=%b exp 1 1", key_ready_o, pt_ready_o);
        end
        encrypt(1'b1, 80'h0, 64'h0, 64'h5579C1387B228445, 0, "collide");
    endtask

    task automatic test_mid_reset;
        bit ok;
        load_key({16'($urandom), $urandom, $urandom});
        pt_i = {$urandom, $urandom};
        pt_valid_i = 1'b1;
        tick;
        pt_valid_i = 1'b0;
        for (int i = 0; i < 16; i++) tick;
        rst_i = 1'b1;
        tick;
        rst_i = 1'b0;
        total++;
        if (ct_valid_o !== 1'b0 || busy_o !== 1'b0 || key_ready_o !== 1'b1 || pt_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL midreset_state got v=%b b=%b kr=%b pr=%b exp 0 0 1 0",
                     ct_valid_o, busy_o, key_ready_o, pt_ready_o);
        end
        ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (ct_valid_o !== 1'b0 || busy_o !== 1'b0) ok = 1'b0;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL midreset_no_output got v=%b b=%b exp 0 0", ct_valid_o, busy_o);
        end
        load_key(80'h0);
        encrypt(1'b0, '0, 64'h0, 64'h5579C1387B228445, 0, "midreset_recover");
    endtask

    task automatic test_random;
        logic [79:0] k;
        logic [63:0] p;
        load_key({16'($urandom), $urandom, $urandom});
        k = cur_key;
        for (int i = 0; i < 8; i++) begin
            p = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) begin
                k = {16'($urandom), $urandom, $urandom};
                encrypt(1'b1, k, p, present80(k, p), int'($urandom_range(0, 5)), "random_newkey");
            end else begin
                encrypt(1'b0, '0, p, present80(k, p), int'($urandom_range(0, 5)), "random_heldkey");
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] p;
        for (int i = 0; i < 3; i++) begin
            p = {$urandom, $urandom};
            encrypt(1'b0, '0, p, present80(cur_key, p), 0, "b2b");
            if (i > 0) begin
                total++;
                if (last_acc - prev_acc !== 35) begin
                    bad++;
                    $display("FAIL b2b_period got=%0d exp=35", last_acc - prev_acc);
                end
            end
        end
    endtask

    initial begin
        rst_i = 1'b0;
        key_i = '0;
        key_valid_i = 1'b0;
        pt_i = '0;
        pt_valid_i = 1'b0;
        ct_ready_i = 1'b1;
        test_reset;
        test_zero_vector;
        test_key_held;
        test_backpressure;
        test_gating;
        test_mid_reset;
        test_random;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
